// File: rtl/cacheline_mem_arbiter.sv
// Two-client cacheline arbiter: I-cache (read) and D-cache (read/write) share one pmem port.
// Optional MEM_ARB_RR_EN selects round-robin on conflict; default is fixed D-over-I priority.
`timescale 1ns/1ps
module cacheline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, any_req, grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // last_d_q: 1 when the most recent grant went to the D-cache
  logic last_d_q;
  assign grant_d = d_req && (!i_req || !last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            last_d_q <= 1'b0;
    else if (state_q == IDLE && any_req) last_d_q <= grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  // State register and pmem request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = grant_d ? SERVE_D : SERVE_I;
      SERVE_I,
      SERVE_D: if (pmem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pmem request capture: latched once at grant, held until pmem_resp
  always_comb begin
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && any_req) begin
      if (grant_d) begin
        // read+write together is illegal; the write wins
        addr_d  = d_addr;
        wr_d    = d_write;
        rd_d    = !d_write;
        wdata_d = d_write ? d_wdata : '0;
      end else begin
        addr_d  = i_addr;
        rd_d    = 1'b1;
        wr_d    = 1'b0;
        wdata_d = '0;
      end
    end else if ((state_q == SERVE_I || state_q == SERVE_D) && pmem_resp) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
    end
  end

  // Output logic: response and data routed only to the current owner
  always_comb begin
    i_resp  = (state_q == SERVE_I) && pmem_resp;
    d_resp  = (state_q == SERVE_D) && pmem_resp;
    i_rdata = (state_q == SERVE_I) ? pmem_rdata : '0;
    d_rdata = (state_q == SERVE_D) ? pmem_rdata : '0;
  end

  assign pmem_addr  = addr_q;
  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_wdata = wdata_q;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Scoreboard bench for cacheline_mem_arbiter: a pmem model checks each grant, a monitor checks each resp.
`timescale 1ns/1ps
module tb_cacheline_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, pmem_addr;
  logic         i_read, d_read, d_write, i_resp, d_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp, pm_resp_q, spur;

  always #5 clk = ~clk;
  assign pmem_resp = pm_resp_q | spur;

  cacheline_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
    int           lat;
    logic [255:0] rdata;
  } pm_t;

  pm_t          pm_q[$];
  logic [255:0] i_q[$], d_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, strobe_cyc = 0;
  bit auto_en = 1'b1, last_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Queue one expected transaction: grant order on pmem plus the owner's response data
  task automatic push(input bit is_d, input logic [31:0] a, input logic wr,
                      input logic [255:0] wd, input int lat, input logic [255:0] rd);
    pm_t e;
    e.addr = a; e.rd = !wr; e.wr = wr; e.wdata = wd; e.lat = lat; e.rdata = rd;
    pm_q.push_back(e);
    if (is_d) d_q.push_back(rd);
    else      i_q.push_back(rd);
    last_d = is_d;
  endtask

  function automatic bit exp_dwin();
`ifdef MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic wait_resp(input bit is_d, input int budget);
    int n = 0;
    do begin tick(); n++; end while (!(is_d ? d_resp : i_resp) && n < budget);
    if (!(is_d ? d_resp : i_resp)) flag(is_d ? "timeout_d_resp" : "timeout_i_resp");
  endtask

  task automatic wait_both(input int budget);
    bit gi = 0, gd = 0;
    int n = 0;
    while (!(gi && gd) && n < budget) begin
      tick(); n++;
      if (i_resp) begin gi = 1; i_read = 1'b0; end
      if (d_resp) begin gd = 1; d_read = 1'b0; end
    end
    if (!(gi && gd)) flag("timeout_both");
  endtask

  // pmem model: checks each new strobe against the expected grant, answers after lat cycles
  initial begin
    pm_t e;
    pm_resp_q = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_en && rst && (pmem_read || pmem_write)) begin
        strobe_cyc = cyc;
        if (pm_q.size() == 0) begin
          flag("unexpected_pmem_strobe");
          while (rst && (pmem_read || pmem_write)) @(negedge clk);
        end else begin
          e = pm_q.pop_front();
          chk("pmem_addr", pmem_addr, e.addr);
          chk("pmem_read", pmem_read, e.rd);
          chk("pmem_write", pmem_write, e.wr);
          if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
          repeat (e.lat) @(negedge clk);
          pmem_rdata = e.rdata;
          pm_resp_q  = 1'b1;
          @(negedge clk);
          pm_resp_q  = 1'b0;
          pmem_rdata = '0;
        end
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      tick();
      if (rst) begin
        if (i_resp && d_resp) flag("both_resp");
        if (i_resp) begin
          if (i_q.size() == 0) flag("unexpected_i_resp");
          else chk("i_rdata", i_rdata, i_q.pop_front());
          chk("d_rdata_nonowner", d_rdata, '0);
        end
        if (d_resp) begin
          if (d_q.size() == 0) flag("unexpected_d_resp");
          else chk("d_rdata", d_rdata, d_q.pop_front());
          chk("i_rdata_nonowner", i_rdata, '0);
        end
      end
    end
  end

  initial begin
    int resp_c, nresp, n;
    rst = 1'b0; spur = 1'b0;
    i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    repeat (3) tick();
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_addr", pmem_addr, '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    rst = 1'b1;

    // Lone I-cache read, 1-cycle grant latency
    tick();
    push(1'b0, 32'h0000_0060, 1'b0, '0, 4, {32{8'hA5}});
    i_addr = 32'h0000_0060; i_read = 1'b1;
    tick();
    chk("grant_latency_read", pmem_read, 1'b1);
    chk("grant_latency_write", pmem_write, 1'b0);
    wait_resp(1'b0, 50);
    i_read = 1'b0;

    // Conflict: D write beats I read; D address/data change mid-serve is ignored
    repeat (2) tick();
    push(1'b1, 32'h8000_0020, 1'b1, {8{32'h1234_5678}}, 4, {32{8'h3C}});
    push(1'b0, 32'h0000_0100, 1'b0, '0, 2, {32{8'h11}});
    d_addr = 32'h8000_0020; d_wdata = {8{32'h1234_5678}}; d_write = 1'b1;
    i_addr = 32'h0000_0100; i_read = 1'b1;
    tick();
    chk("conflict_first_write", pmem_write, 1'b1);
    repeat (2) tick();
    d_addr = 32'hDEAD_0000; d_wdata = ~{8{32'h1234_5678}};
    tick();
    chk("addr_held_mid_serve", pmem_addr, 32'h8000_0020);
    chk("wdata_held_mid_serve", pmem_wdata, {8{32'h1234_5678}});
    wait_resp(1'b1, 50);
    d_write = 1'b0;
    resp_c = cyc;
    wait_resp(1'b0, 50);
    i_read = 1'b0;
    chk("resp_to_next_strobe", 256'(strobe_cyc - resp_c), 256'd3);

    // Lone D read, then a conflict whose winner depends on the arbitration mode
    tick();
    push(1'b1, 32'h0000_0040, 1'b0, '0, 3, {32{8'h5A}});
    d_addr = 32'h0000_0040; d_read = 1'b1;
    wait_resp(1'b1, 50);
    d_read = 1'b0;
    repeat (2) tick();
    if (exp_dwin()) begin
      push(1'b1, 32'h0000_0080, 1'b0, '0, 2, {32{8'h77}});
      push(1'b0, 32'h0000_0200, 1'b0, '0, 2, {32{8'h88}});
    end else begin
      push(1'b0, 32'h0000_0200, 1'b0, '0, 2, {32{8'h88}});
      push(1'b1, 32'h0000_0080, 1'b0, '0, 2, {32{8'h77}});
    end
    d_addr = 32'h0000_0080; d_read = 1'b1;
    i_addr = 32'h0000_0200; i_read = 1'b1;
    wait_both(100);

    // Spurious pmem_resp while idle
    repeat (2) tick();
    spur = 1'b1;
    #1;
    chk("spurious_no_resp", {i_resp, d_resp}, 2'b00);
    tick();
    spur = 1'b0;
    chk("spurious_stays_idle", {pmem_read, pmem_write}, 2'b00);

    // Reset two cycles into SERVE_D abandons the transaction
    auto_en = 1'b0;
    d_addr = 32'h0000_0300; d_read = 1'b1;
    tick();
    chk("rst_test_strobe", pmem_read, 1'b1);
    repeat (2) tick();
    rst = 1'b0; d_read = 1'b0; last_d = 1'b0;
    #1;
    chk("async_rst_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("async_rst_addr", pmem_addr, '0);
    repeat (2) tick();
    rst = 1'b1; auto_en = 1'b1;
    tick();
    chk("post_rst_idle", {pmem_read, pmem_write}, 2'b00);
    push(1'b1, 32'h0000_0340, 1'b0, '0, 2, {32{8'h9C}});
    d_addr = 32'h0000_0340; d_read = 1'b1;
    tick();
    chk("post_rst_grant", pmem_read, 1'b1);
    wait_resp(1'b1, 50);
    d_read = 1'b0;

    // 20 back-to-back transactions with both requesters held
    repeat (2) tick();
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    for (int k = 0; k < 20; k++) begin
      bit dw;
      dw = exp_dwin();
      push(dw, dw ? 32'h0000_2000 : 32'h0000_1000, 1'b0, '0, 1, {32{8'(k + 1)}});
    end
    i_read = 1'b1; d_read = 1'b1;
    nresp = 0; n = 0;
    while (nresp < 20 && n < 600) begin
      tick(); n++;
      if (i_resp || d_resp) nresp++;
    end
    i_read = 1'b0; d_read = 1'b0;
    if (nresp < 20) flag("timeout_stream");

    repeat (6) tick();
    chk("pm_queue_drained", 256'(pm_q.size()), '0);
    chk("i_queue_drained", 256'(i_q.size()), '0);
    chk("d_queue_drained", 256'(d_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
